// File: rtl/simple_uart_tx_pkg.sv
// Shared definitions for the UART transmitter.
//   DATA_W     : width of one transmitted character
//   PERIOD_W   : width of the bit-period value and of the in-bit clock counter
//   tx_state_t : frame state encoding (IDLE=0, START=1, DATA=2, STOP=3)
package simple_uart_tx_pkg;

  localparam int DATA_W   = 8;
  localparam int PERIOD_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/simple_sync_fifo.sv
// Small synchronous FIFO with registered full/empty flags.
// Ports:
//   clk, reset_n : clock (rising edge) and asynchronous active-low reset
//   push, din    : write request and data; ignored while full
//   pop, dout    : read request and head data; dout is combinational from
//                  the read pointer and only meaningful while !empty
//   full, empty  : registered occupancy flags
module simple_sync_fifo #(
  parameter int WIDTH   = 8,
  parameter int FIFO_AW = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0]   r_mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_full;
  logic               r_empty;

  logic [FIFO_AW:0]   w_count_nxt;
  logic               w_push_ok;
  logic               w_pop_ok;

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign w_push_ok = push && !r_full;
  assign w_pop_ok  = pop && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + (FIFO_AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (FIFO_AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + FIFO_AW'(1);
      r_count <= w_count_nxt;
      // The count never exceeds the depth, so its MSB alone means "full".
      r_full  <= w_count_nxt[FIFO_AW];
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage carries no reset; contents are only read behind the empty flag.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= din;
  end

  assign dout  = r_mem[r_rptr];
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/simple_uart_tx.sv
// UART transmitter: a write FIFO feeding an 8N1/8N2 serialiser.
// Parameters:
//   FIFO_AW   : FIFO address width, depth = 2**FIFO_AW (1..4)
//   STOP_BITS : stop bits per frame (1 or 2)
// Ports:
//   clk, reset_n : clock (rising edge) and asynchronous active-low reset
//   i_period     : bit time minus one, in clk cycles; sampled at frame start
//   i_wr, i_data : push a byte into the FIFO
//   i_clr_ovr    : clears o_overrun (a simultaneous dropped write wins)
//   o_ready      : FIFO not full
//   o_empty      : FIFO empty
//   o_busy       : a frame is on the wire (start bit through last stop bit)
//   o_overrun    : sticky, a write arrived while the FIFO was full
//   o_txd        : registered serial output, idles high
//
// Valid/ready: a byte is accepted on any rising edge where i_wr=1 and
// o_ready=1; i_wr while o_ready=0 loses the byte and sets o_overrun.
//
// o_txd and o_busy are registered images of the frame state, so the line
// lags the state machine by one clock. Every segment keeps its length; the
// first start-bit clock appears two edges after the write edge.
module simple_uart_tx #(
  parameter int FIFO_AW   = 2,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] i_period,
  input  logic        i_wr,
  input  logic [7:0]  i_data,
  input  logic        i_clr_ovr,
  output logic        o_ready,
  output logic        o_empty,
  output logic        o_busy,
  output logic        o_overrun,
  output logic        o_txd
);

  import simple_uart_tx_pkg::*;

  // Index of the final stop bit: 0 for one stop bit, 1 for two.
  localparam logic LAST_STOP_IDX = (STOP_BITS == 2);

  tx_state_t           r_state;
  logic [DATA_W-1:0]   r_sh;
  logic [PERIOD_W-1:0] r_per_l;
  logic [PERIOD_W-1:0] r_cnt;
  logic [2:0]          r_bit_idx;
  logic                r_stop_idx;
  logic                r_txd;
  logic                r_busy;
  logic                r_ovr;

  logic [DATA_W-1:0]   w_dout;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_bit_end;
  logic                w_last_stop;

  simple_sync_fifo #(
    .WIDTH   (DATA_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (i_wr),
    .pop     (w_pop),
    .din     (i_data),
    .dout    (w_dout),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_bit_end   = (r_cnt == r_per_l);
  assign w_last_stop = (r_state == ST_STOP) && w_bit_end &&
                       (r_stop_idx == LAST_STOP_IDX);
  // Pop from IDLE, or at the end of the last stop bit for a gapless next frame.
  assign w_pop       = !w_empty && ((r_state == ST_IDLE) || w_last_stop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_sh       <= '0;
      r_per_l    <= '0;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      // Line outputs follow the state held during this cycle.
      case (r_state)
        ST_START: r_txd <= 1'b0;
        ST_DATA:  r_txd <= r_sh[0];
        default:  r_txd <= 1'b1;
      endcase
      r_busy <= (r_state != ST_IDLE);

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_sh    <= w_dout;
            r_per_l <= i_period;
            r_cnt   <= '0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end else begin
            r_cnt <= r_cnt + PERIOD_W'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            r_sh  <= r_sh >> 1;
            if (r_bit_idx == 3'd7) begin
              r_stop_idx <= 1'b0;
              r_state    <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + PERIOD_W'(1);
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_stop_idx == LAST_STOP_IDX) begin
              if (w_pop) begin
                r_sh    <= w_dout;
                r_per_l <= i_period;
                r_state <= ST_START;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_stop_idx <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + PERIOD_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Set has priority so a dropped write is never hidden by a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovr <= 1'b0;
    end else if (i_wr && w_full) begin
      r_ovr <= 1'b1;
    end else if (i_clr_ovr) begin
      r_ovr <= 1'b0;
    end
  end

  assign o_ready   = !w_full;
  assign o_empty   = w_empty;
  assign o_busy    = r_busy;
  assign o_overrun = r_ovr;
  assign o_txd     = r_txd;

endmodule
